// File: rtl/riscv_inst_unpack_stage.sv
// Unpacks raw RISC-V instruction words into fields, format class and sign-extended immediate.
// Registered output stage with a one-entry skid buffer so in_rdy never depends on out_rdy.
module riscv_inst_unpack_stage #(
    parameter int IMM_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [31:0]      in_msg,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [2:0]       out_type,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [2:0]       out_funct3,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [6:0]       out_funct7,
    output logic [IMM_W-1:0] out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_SB  = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_UJ  = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [2:0]       fmt;
        logic [6:0]       opcode;
        logic [4:0]       rd;
        logic [2:0]       funct3;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [6:0]       funct7;
        logic [IMM_W-1:0] imm;
        logic             illegal;
    } dec_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    function automatic dec_t unpack_inst(input logic [31:0] w);
        dec_t              d;
        logic signed [31:0] imm32;
        d        = '0;
        imm32    = '0;
        d.opcode = w[6:0];
        case (w[6:0])
            7'b0110011:                         d.fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111: d.fmt = FMT_I;
            7'b0100011:                         d.fmt = FMT_S;
            7'b1100011:                         d.fmt = FMT_SB;
            7'b0110111, 7'b0010111:             d.fmt = FMT_U;
            7'b1101111:                         d.fmt = FMT_UJ;
            default:                            d.fmt = FMT_ILL;
        endcase
        case (d.fmt)
            FMT_R: begin
                d.rd = w[11:7]; d.funct3 = w[14:12]; d.rs1 = w[19:15];
                d.rs2 = w[24:20]; d.funct7 = w[31:25];
            end
            FMT_I: begin
                d.rd = w[11:7]; d.funct3 = w[14:12]; d.rs1 = w[19:15];
                imm32 = {{20{w[31]}}, w[31:20]};
            end
            FMT_S: begin
                d.funct3 = w[14:12]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
                imm32 = {{20{w[31]}}, w[31:25], w[11:7]};
            end
            FMT_SB: begin
                d.funct3 = w[14:12]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
                imm32 = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            end
            FMT_U: begin
                d.rd = w[11:7];
                imm32 = {w[31:12], 12'b0};
            end
            FMT_UJ: begin
                d.rd = w[11:7];
                imm32 = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            end
            default: begin
                // Illegal words keep their raw register fields but carry no immediate.
                d.rd = w[11:7]; d.funct3 = w[14:12]; d.rs1 = w[19:15];
                d.rs2 = w[24:20]; d.illegal = 1'b1;
            end
        endcase
        d.imm = IMM_W'(imm32);
        return d;
    endfunction

    state_t            state;
    dec_t              out_p1;
    logic              vld_p1;
    logic [31:0]       skid_p0;
    logic              in_rdy_q;
    logic [CNT_W-1:0]  count_q;
    logic              accept;
    logic              drain;

    assign accept = in_val && in_rdy_q;
    assign drain  = vld_p1 && out_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            vld_p1   <= 1'b0;
            in_rdy_q <= 1'b1;
            out_p1   <= '0;
            skid_p0  <= '0;
            count_q  <= '0;
        end else begin
            if (accept) count_q <= count_q + 1'b1;
            case (state)
                EMPTY: if (accept) begin
                    out_p1 <= unpack_inst(in_msg);
                    vld_p1 <= 1'b1;
                    state  <= ONE;
                end
                ONE: begin
                    if (accept && !drain) begin
                        skid_p0  <= in_msg;
                        in_rdy_q <= 1'b0;
                        state    <= FULL;
                    end else if (drain && !accept) begin
                        vld_p1 <= 1'b0;
                        state  <= EMPTY;
                    end else if (accept && drain) begin
                        out_p1 <= unpack_inst(in_msg);
                    end
                end
                FULL: if (drain) begin
                    out_p1   <= unpack_inst(skid_p0);
                    in_rdy_q <= 1'b1;
                    state    <= ONE;
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // ---- output stage p1 ----
    assign in_rdy      = in_rdy_q;
    assign out_val     = vld_p1;
    assign out_type    = out_p1.fmt;
    assign out_opcode  = out_p1.opcode;
    assign out_rd      = out_p1.rd;
    assign out_funct3  = out_p1.funct3;
    assign out_rs1     = out_p1.rs1;
    assign out_rs2     = out_p1.rs2;
    assign out_funct7  = out_p1.funct7;
    assign out_imm     = out_p1.imm;
    assign out_illegal = out_p1.illegal;
    assign out_count   = count_q;

endmodule

// File: tb/tb_riscv_inst_unpack_stage.sv
// Bench for riscv_inst_unpack_stage: directed vector table, back-pressure and reset
// sequences, then a random valid/ready stream against a field-rule reference decoder.
module tb_riscv_inst_unpack_stage;

    localparam int IMM_W = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_val;
    logic             in_rdy;
    logic [31:0]      in_msg;
    logic             out_val;
    logic             out_rdy;
    logic [2:0]       out_type;
    logic [6:0]       out_opcode;
    logic [4:0]       out_rd;
    logic [2:0]       out_funct3;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [6:0]       out_funct7;
    logic [IMM_W-1:0] out_imm;
    logic             out_illegal;
    logic [CNT_W-1:0] out_count;

    always #5 clk = ~clk;

    riscv_inst_unpack_stage #(.IMM_W(IMM_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
        .out_val(out_val), .out_rdy(out_rdy), .out_type(out_type), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_funct3(out_funct3), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct7(out_funct7), .out_imm(out_imm), .out_illegal(out_illegal),
        .out_count(out_count)
    );

    typedef struct packed {
        logic [2:0]  typ;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        ill;
    } dec_t;

    typedef struct {
        logic [31:0] w;
        dec_t        e;
    } vec_t;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [3:0] cnt = '0;
    dec_t       q[$];
    vec_t       tbl[10];

    function automatic dec_t mk(input logic [2:0] t, input logic [6:0] o, input logic [4:0] rd,
                                input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [6:0] f7, input logic [31:0] imm);
        dec_t d;
        d.typ = t; d.opc = o; d.rd = rd; d.f3 = f3; d.rs1 = rs1; d.rs2 = rs2;
        d.f7 = f7; d.imm = imm; d.ill = (t == 3'd7);
        return d;
    endfunction

    // Reference decoder: class from opcode, then each field by its own rule, immediates by weights.
    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t d;
        int   imm;
        d = '0;
        imm = 0;
        d.opc = w[6:0];
        case (w[6:0])
            7'h33:               d.typ = 3'd0;
            7'h13, 7'h03, 7'h67: d.typ = 3'd1;
            7'h23:               d.typ = 3'd2;
            7'h63:               d.typ = 3'd3;
            7'h37, 7'h17:        d.typ = 3'd4;
            7'h6f:               d.typ = 3'd5;
            default:             d.typ = 3'd7;
        endcase
        d.rd  = (d.typ == 3'd2 || d.typ == 3'd3) ? 5'd0 : w[11:7];
        d.f3  = (d.typ == 3'd4 || d.typ == 3'd5) ? 3'd0 : w[14:12];
        d.rs1 = (d.typ == 3'd4 || d.typ == 3'd5) ? 5'd0 : w[19:15];
        d.rs2 = (d.typ == 3'd1 || d.typ == 3'd4 || d.typ == 3'd5) ? 5'd0 : w[24:20];
        d.f7  = (d.typ == 3'd0) ? w[31:25] : 7'd0;
        case (d.typ)
            3'd1: imm = int'(w[31:20]) - (w[31] ? 4096 : 0);
            3'd2: imm = int'(w[31:25]) * 32 + int'(w[11:7]) - (w[31] ? 4096 : 0);
            3'd3: imm = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2
                        - (w[31] ? 4096 : 0);
            3'd4: imm = int'(w & 32'hfffff000);
            3'd5: imm = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2
                        - (w[31] ? 1048576 : 0);
            default: imm = 0;
        endcase
        d.imm = imm;
        d.ill = (d.typ == 3'd7);
        return d;
    endfunction

    function automatic dec_t dut_out();
        dec_t d;
        d.typ = out_type; d.opc = out_opcode; d.rd = out_rd; d.f3 = out_funct3;
        d.rs1 = out_rs1; d.rs2 = out_rs2; d.f7 = out_funct7; d.imm = out_imm;
        d.ill = out_illegal;
        return d;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};

    initial begin
        logic [31:0] a, b, c, d, r;

        tbl[0] = '{32'h8ad98793, mk(3'd1, 7'h13, 5'd15, 3'd0, 5'd19, 5'd0, 7'd0, 32'hfffff8ad)};
        tbl[1] = '{32'hdeadb8b7, mk(3'd4, 7'h37, 5'd17, 3'd0, 5'd0, 5'd0, 7'd0, 32'hdeadb000)};
        tbl[2] = '{{7'b0011111, 5'd30, 5'd17, 3'd0, 5'b01111, 7'b1100011},
                   mk(3'd3, 7'h63, 5'd0, 3'd0, 5'd17, 5'd30, 7'd0, 32'h00000bee)};
        tbl[3] = '{{1'b1, 10'b1111100101, 1'b1, 8'h4d, 5'd1, 7'b1101111},
                   mk(3'd5, 7'h6f, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hfff4dfca)};
        tbl[4] = '{32'hfe12a0ff, mk(3'd7, 7'h7f, 5'd1, 3'd2, 5'd5, 5'd1, 7'd0, 32'h0)};
        tbl[5] = '{32'h402081b3, mk(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h20, 32'h0)};
        tbl[6] = '{{7'h7f, 5'd5, 5'd2, 3'd2, 5'b11100, 7'b0100011},
                   mk(3'd2, 7'h23, 5'd0, 3'd2, 5'd2, 5'd5, 7'd0, 32'hfffffffc)};
        tbl[7] = '{32'h00001017, mk(3'd4, 7'h17, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'h00001000)};
        tbl[8] = '{32'h000080e7, mk(3'd1, 7'h67, 5'd1, 3'd0, 5'd1, 5'd0, 7'd0, 32'h0)};
        tbl[9] = '{32'h7ff0a103, mk(3'd1, 7'h03, 5'd2, 3'd2, 5'd1, 5'd0, 7'd0, 32'h000007ff)};

        reset = 1'b1; in_val = 1'b0; in_msg = '0; out_rdy = 1'b0;
        repeat (2) cyc();
        chk("rst_out_val", out_val, 1'b0);
        chk("rst_in_rdy", in_rdy, 1'b1);
        chk("rst_count", out_count, 4'd0);
        chk("rst_data", dut_out(), '0);
        @(negedge clk) reset = 1'b0;

        // Directed table, one word per cycle with the consumer always ready.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_val = 1'b1; in_msg = tbl[i].w; out_rdy = 1'b1;
            cyc();
            cnt++;
            chk("tbl_val", out_val, 1'b1);
            chk($sformatf("tbl_dec[%0d]", i), dut_out(), tbl[i].e);
            chk("tbl_count", out_count, cnt);
        end
        @(negedge clk) in_val = 1'b0;
        cyc();
        chk("tbl_drain_val", out_val, 1'b0);

        // Back-pressure: three words while the consumer stalls.
        a = 32'h00100093; b = 32'h00200113; c = 32'h00300193;
        @(negedge clk) begin in_val = 1'b1; in_msg = a; out_rdy = 1'b0; end
        cyc(); cnt++;
        chk("bp_rdy_one", in_rdy, 1'b1);
        chk("bp_out_a", dut_out(), ref_decode(a));
        @(negedge clk) in_msg = b;
        cyc(); cnt++;
        chk("bp_rdy_full", in_rdy, 1'b0);
        chk("bp_hold_a", dut_out(), ref_decode(a));
        @(negedge clk) in_msg = c;
        cyc();
        chk("bp_still_full", in_rdy, 1'b0);
        chk("bp_hold_a2", dut_out(), ref_decode(a));
        chk("bp_count", out_count, cnt);
        @(negedge clk) out_rdy = 1'b1;
        cyc();
        chk("bp_out_b", dut_out(), ref_decode(b));
        chk("bp_val_b", out_val, 1'b1);
        chk("bp_rdy_back", in_rdy, 1'b1);
        cyc(); cnt++;
        chk("bp_out_c", dut_out(), ref_decode(c));
        chk("bp_val_c", out_val, 1'b1);
        @(negedge clk) in_val = 1'b0;
        cyc();
        chk("bp_empty", out_val, 1'b0);
        chk("bp_count_end", out_count, cnt);

        // Reset asserted while both entries are occupied.
        @(negedge clk) begin in_val = 1'b1; in_msg = a; out_rdy = 1'b0; end
        cyc();
        @(negedge clk) in_msg = b;
        cyc();
        chk("rs_full", in_rdy, 1'b0);
        #2 reset = 1'b1;
        #1;
        cnt = '0;
        chk("rs_out_val", out_val, 1'b0);
        chk("rs_in_rdy", in_rdy, 1'b1);
        chk("rs_count", out_count, cnt);
        @(negedge clk) begin reset = 1'b0; in_val = 1'b0; out_rdy = 1'b1; end
        cyc();
        chk("rs_no_emit", out_val, 1'b0);
        d = 32'hdeadb8b7;
        @(negedge clk) begin in_val = 1'b1; in_msg = d; end
        cyc(); cnt++;
        chk("rs_first_val", out_val, 1'b1);
        chk("rs_first_dec", dut_out(), ref_decode(d));
        chk("rs_first_count", out_count, cnt);
        @(negedge clk) in_val = 1'b0;
        cyc();
        chk("rs_drained", out_val, 1'b0);

        // Random valid/ready stream against the reference queue.
        for (int k = 0; k < 10020; k++) begin
            @(negedge clk);
            chk("rnd_val", out_val, q.size() > 0);
            chk("rnd_rdy", in_rdy, q.size() < 2);
            chk("rnd_count", out_count, cnt);
            if (out_val && q.size() > 0) chk("rnd_data", dut_out(), q[0]);
            if (k < 10000) begin
                r = $urandom;
                if ($urandom_range(7) != 0) r[6:0] = ops[$urandom_range(8)];
                in_msg  = r;
                in_val  = ($urandom_range(3) != 0);
                out_rdy = ((k / 200) % 3 == 2) ? ($urandom_range(3) == 0) : ($urandom_range(2) != 0);
            end else begin
                in_val  = 1'b0;
                out_rdy = 1'b1;
            end
            #1;
            if (out_val && out_rdy && q.size() > 0) void'(q.pop_front());
            if (in_val && in_rdy) begin
                q.push_back(ref_decode(in_msg));
                cnt++;
            end
        end
        chk("rnd_final_empty", out_val, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
